// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
//   NRD combinational read ports, NWR write ports, optional same-cycle
//   write-to-read bypass, and a per-register busy scoreboard for in-flight
//   producers. Entry 0 reads as zero. After reset a clear engine zeroes one
//   entry per cycle, so the array can map onto SRAM/LUTRAM.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   rden_i/raddr_i      per-port read enable / address (port i at [i*AW +: AW])
//   rdata_o/rbusy_o     per-port read data / busy flag (combinational)
//   wren_i/waddr_i/wdata_i  per-port write enable / address / data
//   rsv_en_i/rsv_addr_i reserve request: mark rsv_addr_i busy
//   ready_o             clear finished, array usable (registered)
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD-1:0]       rden_i,
  input  logic [NRD*AW-1:0]    raddr_i,
  output logic [NRD*XLEN-1:0]  rdata_o,
  output logic [NRD-1:0]       rbusy_o,
  input  logic [NWR-1:0]       wren_i,
  input  logic [NWR*AW-1:0]    waddr_i,
  input  logic [NWR*XLEN-1:0]  wdata_i,
  input  logic                 rsv_en_i,
  input  logic [AW-1:0]        rsv_addr_i,
  output logic                 ready_o
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] mem_q [NREG];

  logic run;
  assign run     = (state_q == S_RUN);
  assign ready_o = ready_q;

  // Next state, clear counter and scoreboard. Within RUN, writes retire
  // their producer first and the reserve is applied last, so a same-cycle
  // reserve (the newer producer) leaves the entry busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREG-1)) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end
      end
      S_RUN: begin
        for (int j = 0; j < NWR; j++)
          if (wren_i[j] && waddr_i[j*AW +: AW] != '0)
            busy_d[waddr_i[j*AW +: AW]] = 1'b0;
        if (rsv_en_i && rsv_addr_i != '0)
          busy_d[rsv_addr_i] = 1'b1;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Storage carries no reset so it can map to RAM; the clear engine owns
  // its initial contents. Later write ports override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == S_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else begin
        for (int j = 0; j < NWR; j++)
          if (wren_i[j] && waddr_i[j*AW +: AW] != '0)
            mem_q[waddr_i[j*AW +: AW]] <= wdata_i[j*XLEN +: XLEN];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr_i[i*AW +: AW];
    regfile_mp_rdport #(
      .XLEN(XLEN), .AW(AW), .NWR(NWR), .BYPASS(BYPASS)
    ) u_rd (
      .run_i     (run),
      .rden_i    (rden_i[i]),
      .raddr_i   (ra),
      .mem_rd_i  (mem_q[ra]),
      .busy_rd_i (busy_q[ra]),
      .wren_i    (wren_i),
      .waddr_i   (waddr_i),
      .wdata_i   (wdata_i),
      .rdata_o   (rdata_o[i*XLEN +: XLEN]),
      .rbusy_o   (rbusy_o[i])
    );
  end

endmodule

// regfile_mp_rdport: one combinational read port.
//   run_i gates everything to zero during clear; address 0 and disabled
//   ports read zero / not busy. With BYPASS, a same-cycle write to the
//   addressed register is forwarded (highest port wins) and reads not busy,
//   since that write is the producer completing.
module regfile_mp_rdport #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                run_i,
  input  logic                rden_i,
  input  logic [AW-1:0]       raddr_i,
  input  logic [XLEN-1:0]     mem_rd_i,
  input  logic                busy_rd_i,
  input  logic [NWR-1:0]      wren_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  output logic [XLEN-1:0]     rdata_o,
  output logic                rbusy_o
);

  always_comb begin
    rdata_o = '0;
    rbusy_o = 1'b0;
    if (run_i && rden_i && raddr_i != '0) begin
      rdata_o = mem_rd_i;
      rbusy_o = busy_rd_i;
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++)
          if (wren_i[j] && waddr_i[j*AW +: AW] == raddr_i) begin
            rdata_o = wdata_i[j*XLEN +: XLEN];
            rbusy_o = 1'b0;
          end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (no bypass / bypass), NRD=2, NWR=2,
// driven with identical stimulus. Each cycle the expected outputs are
// derived from a behavioural model, pushed to a queue, and popped and
// compared on the falling edge.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  rden;
  logic [9:0]  raddr;
  logic [1:0]  wren;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  logic [63:0] rdata_nb, rdata_bp;
  logic [1:0]  rbusy_nb, rbusy_bp;
  logic        ready_nb, ready_bp;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .rden_i(rden), .raddr_i(raddr),
    .rdata_o(rdata_nb), .rbusy_o(rbusy_nb), .wren_i(wren), .waddr_i(waddr),
    .wdata_i(wdata), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .ready_o(ready_nb)
  );

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) u_bp (
    .clk(clk), .rst(rst), .rden_i(rden), .raddr_i(raddr),
    .rdata_o(rdata_bp), .rbusy_o(rbusy_bp), .wren_i(wren), .waddr_i(waddr),
    .wdata_i(wdata), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .ready_o(ready_bp)
  );

  typedef struct packed {
    logic        rdy;
    logic [63:0] d_nb;
    logic [63:0] d_bp;
    logic [1:0]  b_nb;
    logic [1:0]  b_bp;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference model state
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  logic        m_ready;
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void rd_model(input bit bp, output logic [63:0] d, output logic [1:0] b);
    logic [4:0]  ra;
    logic [31:0] di;
    logic        bi;
    for (int i = 0; i < 2; i++) begin
      ra = raddr[i*5 +: 5];
      di = '0;
      bi = 1'b0;
      if (m_ready && rden[i] && ra != 5'd0) begin
        di = m_mem[ra];
        bi = m_busy[ra];
        if (bp)
          for (int j = 0; j < 2; j++)
            if (wren[j] && waddr[j*5 +: 5] == ra) begin
              di = wdata[j*32 +: 32];
              bi = 1'b0;
            end
      end
      d[i*32 +: 32] = di;
      b[i] = bi;
    end
  endfunction

  task automatic model_edge();
    logic [4:0] wa;
    if (!rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      m_busy  = '0;
    end else if (!m_ready) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == 31) m_ready = 1'b1;
      m_cnt = (m_cnt + 1) % 32;
    end else begin
      for (int j = 0; j < 2; j++) begin
        wa = waddr[j*5 +: 5];
        if (wren[j] && wa != 5'd0) begin
          m_mem[wa] = wdata[j*32 +: 32];
          m_busy[wa] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  // One clock: predict, compare on the falling edge, advance model at the
  // rising edge, then return just after it so the caller can drive again.
  task automatic tick();
    exp_t e;
    exp_t p;
    e.rdy = m_ready;
    rd_model(1'b0, e.d_nb, e.b_nb);
    rd_model(1'b1, e.d_bp, e.b_bp);
    exp_q.push_back(e);
    @(negedge clk);
    p = exp_q.pop_front();
    chk("ready_nb", 64'(ready_nb), 64'(p.rdy));
    chk("ready_bp", 64'(ready_bp), 64'(p.rdy));
    chk("rdata0_nb", 64'(rdata_nb[31:0]),  64'(p.d_nb[31:0]));
    chk("rdata1_nb", 64'(rdata_nb[63:32]), 64'(p.d_nb[63:32]));
    chk("rdata0_bp", 64'(rdata_bp[31:0]),  64'(p.d_bp[31:0]));
    chk("rdata1_bp", 64'(rdata_bp[63:32]), 64'(p.d_bp[63:32]));
    chk("rbusy_nb", 64'(rbusy_nb), 64'(p.b_nb));
    chk("rbusy_bp", 64'(rbusy_bp), 64'(p.b_bp));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wren   = '0;
    waddr  = '0;
    wdata  = '0;
    rsv_en = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rden  = 2'b11;
    raddr = {a1, a0};
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wren[p] = 1'b1;
    waddr[p*5 +: 5] = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic rnd(input int amax);
    rden     = 2'($urandom);
    raddr    = {5'($urandom_range(0, amax)), 5'($urandom_range(0, amax))};
    wren     = 2'($urandom);
    waddr    = {5'($urandom_range(0, amax)), 5'($urandom_range(0, amax))};
    wdata    = {32'($urandom), 32'($urandom)};
    rsv_en   = 1'($urandom);
    rsv_addr = 5'($urandom_range(0, amax));
  endtask

  initial begin
    for (int k = 0; k < 32; k++) m_mem[k] = '0;
    m_busy = '0; m_ready = 1'b0; m_cnt = 0;
    rst = 1'b0; rden = '0; raddr = '0;
    idle();
    repeat (2) @(posedge clk);
    model_edge();
    #1;

    // Reset state, reads enabled
    rd(5'd1, 5'd2);
    tick();

    // Clear with write/reserve noise that must be ignored
    rst = 1'b1;
    for (int k = 0; k < 32; k++) begin rnd(31); tick(); end
    idle();
    for (int k = 1; k < 32; k += 2) begin rd(5'(k), 5'(k + 1)); tick(); end

    // Preload, then a 1-cycle reset pulse
    for (int k = 1; k < 32; k++) begin
      idle(); wr(0, 5'(k), 32'($urandom)); rd(5'(k), 5'(k)); tick();
    end
    idle(); rst = 1'b0; tick();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b0; tick();            // restart mid-clear
    rst = 1'b1;
    for (int k = 0; k < 34; k++) tick();
    for (int k = 1; k < 32; k += 2) begin rd(5'(k), 5'(k + 1)); tick(); end

    // Basic write/read and x0
    idle(); rd(5'd5, 5'd5); wr(0, 5'd5, 32'hDEADBEEF); tick();
    idle(); tick();
    rd(5'd0, 5'd0); wr(0, 5'd0, 32'h1234); tick();
    idle(); tick();

    // Same-cycle bypass
    rd(5'd7, 5'd7); wr(0, 5'd7, 32'hA5A5A5A5); tick();
    idle(); tick();

    // Multi-write, same and different addresses
    rd(5'd3, 5'd3); wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22); tick();
    idle(); tick();
    rd(5'd3, 5'd4); wr(0, 5'd3, 32'h33); wr(1, 5'd4, 32'h44); tick();
    idle(); tick();

    // Scoreboard
    rd(5'd9, 5'd9); rsv_en = 1'b1; rsv_addr = 5'd9; tick();
    idle(); tick();
    wr(0, 5'd9, 32'h55); tick();
    idle(); tick();
    rsv_en = 1'b1; rsv_addr = 5'd9; wr(1, 5'd9, 32'h66); tick();
    idle(); tick();
    rsv_en = 1'b1; rsv_addr = 5'd9; tick();
    idle(); tick();
    rd(5'd0, 5'd9); rsv_en = 1'b1; rsv_addr = 5'd0; tick();
    idle(); tick();

    // Disabled ports
    rden = 2'b00; raddr = {5'd9, 5'd3}; tick();
    rden = 2'b10; tick();

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      rnd(7);
      rst = ($urandom_range(0, 150) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
